xor_cipher_key_loader: RTL and testbench
========================================

# xor_cipher_key_loader

Sequencer that owns the key-configuration chain of the dual XOR stream cipher. On request it serially shifts an M-bit key into the cipher's configuration shift register, then shifts it through a second time to read it back and check it. It holds the cipher's transmit/receive enables low until a verified key is in place. Sits between the host-side register/pin interface and the cipher core, on the same clock as the core.

## Interface
- M, 32, key length in bits; equals the cipher's config chain length; M >= 2
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_req  in  1  request to load key_in; sampled only in IDLE
- key_in  in  M  key to load; captured on the accepting edge
- tx_en_req  in  1  host wants the transmit path running
- rx_en_req  in  1  host wants the receive path running
- cfg_sdi  in  1  serial data back from cipher chain (cipher cfg_o)
- cfg_en  out  1  shift enable to cipher chain
- cfg_sdo  out  1  serial data into cipher chain (cipher cfg_i)
- tx_en  out  1  gated transmit enable to cipher
- rx_en  out  1  gated receive enable to cipher
- busy  out  1  high in LOAD and VERIFY
- key_valid  out  1  verified key present in chain
- load_done  out  1  one-cycle pulse, load finished and verified
- load_err  out  1  sticky readback mismatch flag; cleared on next accepted load_req

## Operation
- Cipher chain contract: M-bit shift register; on an edge with cfg_en=1 it shifts cfg_sdo in; cfg_sdi shows the oldest stage combinationally.
- States: IDLE, LOAD, VERIFY.
- IDLE: cfg_en=0, cfg_sdo=0. load_req=1 on an edge -> capture key_in into shadow register, clear bit counter, clear load_err, clear key_valid, go LOAD.
- LOAD: cfg_en=1, cfg_sdo=shadow[M-1-cnt] (MSB first), cnt increments each edge; edge with cnt=M-1 -> cnt=0, go VERIFY.
- VERIFY: cfg_en=1, cfg_sdo=shadow[M-1-cnt] again (re-circulates the same key, chain contents preserved); on each edge compare cfg_sdi against shadow[M-1-cnt]; any mismatch sets a local mismatch bit. Edge with cnt=M-1 -> go IDLE; if no mismatch (including the final bit): key_valid=1, load_done pulses; else load_err=1, key_valid stays 0.
- Counter width $clog2(M); never exceeds M-1.
- tx_en = tx_en_req & key_valid & ~busy; rx_en = rx_en_req & key_valid & ~busy (registered, see Timing).
- load_req while busy: ignored, not queued. load_req held high in IDLE after completion: starts a new load on the next edge.
- key_in changes during LOAD/VERIFY have no effect (shadow register used).

## Timing
- Reset values: state=IDLE, cfg_en=0, cfg_sdo=0, tx_en=0, rx_en=0, busy=0, key_valid=0, load_done=0, load_err=0, cnt=0, shadow=0.
- cfg_en, cfg_sdo, busy are decoded from registered state (no combinational path from load_req).
- Accepting edge E0: cfg_en high from E0 through the edge E0+2M (exactly 2M shift edges: E0+1..E0+2M).
- load_done/key_valid/load_err update on edge E0+2M; load_done high for the cycle after E0+2M only.
- tx_en/rx_en are registered: drop to 0 on edge E0 (same edge busy rises) so the cipher never runs during a shift; re-assert no earlier than edge E0+2M+1 and only if key_valid.
- Enable request changes outside a load reach tx_en/rx_en one edge later.
- rst_n asserted mid-LOAD/VERIFY: immediate return to reset values; chain contents undefined, key_valid=0 until a full new load completes.

## Test plan
- Reset: rst_n=0 with all inputs toggling -> all outputs 0; release, no load_req -> outputs stay 0, tx_en=0 despite tx_en_req=1.
- Nominal load, M=32, key_in=32'hA5C3_0F96, bench chain model looped back -> cfg_en high exactly 64 cycles, cfg_sdo sequence = key MSB-first twice, load_done one pulse at edge E0+64, key_valid=1, chain model holds 32'hA5C3_0F96.
- Enable gating: tx_en_req=rx_en_req=1 after valid load -> tx_en=rx_en=1; new load_req -> both 0 on accepting edge, back to 1 one edge after load_done.
- Readback error: bench flips cfg_sdi on VERIFY bit 17 -> load_err=1, load_done never pulses, key_valid=0, tx_en stays 0; next good load clears load_err.
- Busy ignore: second load_req with different key at E0+10 -> no restart, 64 shift cycles total, chain holds first key.
- Mid-load reset: rst_n low at E0+40 -> all outputs 0 asynchronously; subsequent load with 32'h0000_0001 completes with key_valid=1.

Source files
------------

// File: rtl/xor_cipher_key_loader.sv
// xor_cipher_key_loader
// Serially loads an M-bit key into the XOR cipher's configuration chain,
// recirculates it once more to read it back and verify it, and keeps the
// cipher's transmit/receive enables low until a verified key is in place.
module xor_cipher_key_loader #(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_req,
  input  logic [M-1:0] key_in,
  input  logic         tx_en_req,
  input  logic         rx_en_req,
  input  logic         cfg_sdi,
  output logic         cfg_en,
  output logic         cfg_sdo,
  output logic         tx_en,
  output logic         rx_en,
  output logic         busy,
  output logic         key_valid,
  output logic         load_done,
  output logic         load_err
);

  localparam int CW = (M > 2) ? $clog2(M) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [M-1:0]  shadow_reg;
  logic          mismatch_reg;
  logic          key_valid_reg;
  logic          load_done_reg;
  logic          load_err_reg;
  logic          tx_en_reg;
  logic          rx_en_reg;

  logic [CW-1:0] bit_idx;
  logic          cur_bit;
  logic          cnt_last;
  logic          bit_miss;

  // Key is sent MSB first: bit position counts down as cnt counts up.
  assign bit_idx  = CNT_LAST - cnt_reg;
  assign cur_bit  = shadow_reg[bit_idx];
  assign cnt_last = (cnt_reg == CNT_LAST);
  // During VERIFY the chain's oldest stage must equal the bit being re-sent.
  assign bit_miss = (cfg_sdi != cur_bit);

  // Chain-facing controls decode from registered state only, so load_req
  // never reaches the cipher combinationally.
  assign busy    = (state_reg != ST_IDLE);
  assign cfg_en  = busy;
  assign cfg_sdo = busy & cur_bit;

  assign tx_en     = tx_en_reg;
  assign rx_en     = rx_en_reg;
  assign key_valid = key_valid_reg;
  assign load_done = load_done_reg;
  assign load_err  = load_err_reg;

  // Load/verify sequencer with registered status flags and gated enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      shadow_reg    <= '0;
      mismatch_reg  <= 1'b0;
      key_valid_reg <= 1'b0;
      load_done_reg <= 1'b0;
      load_err_reg  <= 1'b0;
      tx_en_reg     <= 1'b0;
      rx_en_reg     <= 1'b0;
    end else begin
      load_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (load_req) begin
            shadow_reg    <= key_in;
            cnt_reg       <= '0;
            mismatch_reg  <= 1'b0;
            load_err_reg  <= 1'b0;
            key_valid_reg <= 1'b0;
            // Enables drop on the same edge busy rises.
            tx_en_reg     <= 1'b0;
            rx_en_reg     <= 1'b0;
            state_reg     <= ST_LOAD;
          end else begin
            tx_en_reg <= tx_en_req & key_valid_reg;
            rx_en_reg <= rx_en_req & key_valid_reg;
          end
        end

        ST_LOAD: begin
          tx_en_reg <= 1'b0;
          rx_en_reg <= 1'b0;
          if (cnt_last) begin
            cnt_reg   <= '0;
            state_reg <= ST_VERIFY;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        ST_VERIFY: begin
          tx_en_reg <= 1'b0;
          rx_en_reg <= 1'b0;
          if (cnt_last) begin
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
            // Final bit is folded in here rather than via mismatch_reg.
            if (mismatch_reg | bit_miss) begin
              load_err_reg <= 1'b1;
            end else begin
              key_valid_reg <= 1'b1;
              load_done_reg <= 1'b1;
            end
          end else begin
            cnt_reg      <= cnt_reg + CW'(1);
            mismatch_reg <= mismatch_reg | bit_miss;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          tx_en_reg <= 1'b0;
          rx_en_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_cipher_key_loader.sv
// Self-checking bench for xor_cipher_key_loader with a looped-back chain model.
module tb_xor_cipher_key_loader;

  localparam int M = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_req = 1'b0;
  logic [M-1:0] key_in = '0;
  logic         tx_en_req = 1'b0;
  logic         rx_en_req = 1'b0;
  logic         cfg_sdi;
  logic         cfg_en, cfg_sdo, tx_en, rx_en, busy, key_valid, load_done, load_err;

  int vectors = 0;
  int errors  = 0;

  // Behavioural cipher chain: M-bit shift register, oldest stage visible.
  logic [M-1:0] chain = '0;
  logic         cfg_flip = 1'b0;
  bit           seq[$];
  int           en_count = 0;

  assign cfg_sdi = chain[M-1] ^ cfg_flip;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cfg_en) begin
      chain <= {chain[M-2:0], cfg_sdo};
      seq.push_back(cfg_sdo);
      en_count++;
    end
  end

  xor_cipher_key_loader #(.M(M)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .key_in(key_in),
    .tx_en_req(tx_en_req), .rx_en_req(rx_en_req), .cfg_sdi(cfg_sdi),
    .cfg_en(cfg_en), .cfg_sdo(cfg_sdo), .tx_en(tx_en), .rx_en(rx_en),
    .busy(busy), .key_valid(key_valid), .load_done(load_done), .load_err(load_err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] all_outs();
    return {cfg_en, cfg_sdo, tx_en, rx_en, busy, key_valid, load_done, load_err};
  endfunction

  // One load: flip_at = VERIFY bit to corrupt (-1 none), poke_at = edge offset
  // of a spurious load_req while busy (-1 none), rst_at = edge offset at which
  // reset is asserted (-1 none).
  task automatic do_load(input logic [M-1:0] key, input int flip_at,
                         input int poke_at, input int rst_at);
    logic        good;
    logic [63:0] exp_seq;
    logic [63:0] act_seq;
    good = (flip_at < 0);
    en_count = 0;
    seq.delete();
    load_req = 1'b1;
    key_in   = key;
    @(posedge clk); #1;
    load_req = 1'b0;
    key_in   = ~key;
    chk("accept", {57'd0, busy, cfg_en, tx_en, rx_en, key_valid, load_err, load_done},
        {57'd0, 7'b1100000});
    for (int i = 1; i <= 2 * M; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("midrst_async", {56'd0, all_outs()}, 64'd0);
        @(posedge clk); #1;
        chk("midrst_hold", {56'd0, all_outs()}, 64'd0);
        rst_n = 1'b1;
        $display("load key=%08h aborted by reset at E0+%0d", key, i);
        return;
      end
      load_req = (i == poke_at);
      if (i == poke_at) key_in = key ^ M'($urandom | 1);
      cfg_flip = (flip_at >= 0) && (i == M + 1 + flip_at);
      @(posedge clk); #1;
      load_req = 1'b0;
      if (i < 2 * M)
        chk("shifting", {59'd0, cfg_en, busy, load_done, tx_en, rx_en}, {59'd0, 5'b11000});
      else
        chk("complete", {57'd0, cfg_en, busy, load_done, key_valid, load_err, tx_en, rx_en},
            {57'd0, 2'b00, good, good, ~good, 2'b00});
    end
    cfg_flip = 1'b0;
    chk("shift_edges", 64'(en_count), 64'(2 * M));
    exp_seq = '0;
    act_seq = '0;
    for (int k = 0; k < 2 * M; k++) begin
      exp_seq[2*M-1-k] = key[M-1-(k % M)];
      if (k < seq.size()) act_seq[2*M-1-k] = seq[k];
    end
    chk("sdo_sequence", act_seq, exp_seq);
    chk("chain_contents", 64'(chain), 64'(key));
    @(posedge clk); #1;
    chk("after_done", {59'd0, load_done, key_valid, load_err, tx_en, rx_en},
        {59'd0, 1'b0, good, ~good, tx_en_req & good, rx_en_req & good});
    $display("load key=%08h flip=%0d poke=%0d valid=%0b err=%0b tx=%0b rx=%0b",
             key, flip_at, poke_at, key_valid, load_err, tx_en, rx_en);
  endtask

  initial begin
    // Reset held with toggling inputs.
    for (int c = 0; c < 4; c++) begin
      load_req  = 1'($urandom);
      key_in    = M'($urandom);
      tx_en_req = 1'($urandom);
      rx_en_req = 1'($urandom);
      @(posedge clk); #1;
      chk("reset_outs", {56'd0, all_outs()}, 64'd0);
    end
    load_req  = 1'b0;
    tx_en_req = 1'b1;
    rx_en_req = 1'b1;
    rst_n     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_reset_idle", {56'd0, all_outs()}, 64'd0);
    end
    $display("reset checks done");

    // Nominal load, enables requested throughout.
    do_load(32'hA5C3_0F96, -1, -1, -1);

    // Enable request changes outside a load take one edge.
    tx_en_req = 1'b0;
    @(posedge clk); #1;
    chk("tx_req_drop", {62'd0, tx_en, rx_en}, {62'd0, 2'b01});
    tx_en_req = 1'b1;
    @(posedge clk); #1;
    chk("tx_req_rise", {62'd0, tx_en, rx_en}, {62'd0, 2'b11});
    $display("enable request follow checked tx=%0b rx=%0b", tx_en, rx_en);

    // Reload gates the enables off, then restores them.
    do_load(M'($urandom), -1, -1, -1);

    // Readback error on VERIFY bit 17, then a good load clears it.
    do_load(M'($urandom), 17, -1, -1);
    @(posedge clk); #1;
    chk("err_sticky", {61'd0, load_err, key_valid, tx_en}, {61'd0, 3'b100});
    do_load(M'($urandom), -1, -1, -1);

    // load_req while busy is ignored.
    do_load(32'h1357_9BDF, -1, 10, -1);

    // Reset mid-load, then a fresh load of 1.
    do_load(M'($urandom), -1, -1, 40);
    chk("after_midrst", {56'd0, all_outs()}, 64'd0);
    do_load(32'h0000_0001, -1, -1, -1);

    // Randomized loads with random enable requests and occasional errors.
    for (int r = 0; r < 5; r++) begin
      tx_en_req = 1'($urandom);
      rx_en_req = 1'($urandom);
      do_load(M'($urandom), (r == 2) ? int'($urandom_range(M - 1, 0)) : -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
